// File: rtl/ballot_controller.sv
// ballot_controller: single-booth poll sequencer.
// Walks a poll through CLOSED -> OPEN -> (ARMED -> GRANT -> LOCKOUT)* -> FINAL.
// It issues one-hot vote increments, counts accepted ballots (saturating at 1023) and
// drives the result display once the poll is final.
// Build option: define BALLOT_TIMEOUT_EN to abandon an armed ballot after TIMEOUT_CYCLES
// idle cycles. Without it, ARMED waits forever and no timeout counter is built.
module ballot_controller #(
    parameter int unsigned LOCKOUT_CYCLES = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       open_poll,
    input  logic       close_poll,
    input  logic       voter_auth,
    input  logic [3:0] vote_req,
    output logic [3:0] vote_grant,
    output logic [9:0] ballot_cnt,
    output logic       busy,
    output logic       err_multi,
    output logic       timeout,
    output logic       disp_en,
    output logic [1:0] disp_sel,
    output logic [2:0] state_o
);

    // Zero-length busy or abandonment periods would make the counters below meaningless.
    if (LOCKOUT_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_cfg_check
        $error("ballot_controller: LOCKOUT_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    localparam int unsigned LockW  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [9:0]  CntMax = 10'd1023;

    typedef enum logic [2:0] {
        StClosed  = 3'd0,
        StOpen    = 3'd1,
        StArmed   = 3'd2,
        StGrant   = 3'd3,
        StLockout = 3'd4,
        StFinal   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               pend_q, pend_d;
    logic [3:0]         grant_q, grant_d;
    logic [9:0]         cnt_q, cnt_d;
    logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
    logic               err_q, err_d;
    logic [1:0]         sel_q, sel_d;

    logic               req_single;
    logic               req_multi;
    logic               lock_done;
    logic               tmo_expire;
    logic [1:0]         low_idx;

    // Classify the candidate request vector: exactly one bit vs. an ambiguous ballot.
    always_comb begin
        req_single = (vote_req != 4'd0) && ((vote_req & (vote_req - 4'd1)) == 4'd0);
        req_multi  = (vote_req != 4'd0) && !req_single;
    end

    // Index of the lowest set request bit, used to pick the displayed candidate.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (vote_req[i]) begin
                low_idx = i[1:0];
            end
        end
    end

    // Lockout counter starts at zero on LOCKOUT entry, so LOCKOUT lasts LOCKOUT_CYCLES cycles.
    assign lock_done = (lock_cnt_q == LockW'(LOCKOUT_CYCLES - 1));

    // Next-state and datapath updates for the poll FSM.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        lock_cnt_d = lock_cnt_q;
        err_d      = 1'b0;
        sel_d      = sel_q;

        case (state_q)
            StClosed: begin
                // Contradictory officer inputs keep the poll shut.
                if (open_poll && !close_poll) begin
                    state_d = StOpen;
                end
            end
            StOpen: begin
                if (close_poll) begin
                    state_d = StFinal;
                end else if (voter_auth) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                // A close abandons the ballot before any vote on the same cycle is taken.
                if (close_poll || pend_q) begin
                    pend_d  = 1'b1;
                    state_d = StFinal;
                end else if (req_single) begin
                    grant_d = vote_req;
                    state_d = StGrant;
                end else begin
                    err_d = req_multi;
                    if (tmo_expire) begin
                        state_d = StOpen;
                    end
                end
            end
            StGrant: begin
                pend_d     = pend_q | close_poll;
                lock_cnt_d = '0;
                state_d    = StLockout;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StLockout: begin
                pend_d = pend_q | close_poll;
                if (lock_done) begin
                    state_d = (pend_q || close_poll) ? StFinal : StOpen;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            StFinal: begin
                if (vote_req != 4'd0) begin
                    sel_d = low_idx;
                end
            end
            default: begin
                state_d = StClosed;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StClosed;
            pend_q     <= 1'b0;
            grant_q    <= 4'd0;
            cnt_q      <= 10'd0;
            lock_cnt_q <= '0;
            err_q      <= 1'b0;
            sel_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            lock_cnt_q <= lock_cnt_d;
            err_q      <= err_d;
            sel_q      <= sel_d;
        end
    end

`ifdef BALLOT_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_q, tmo_d;

    assign tmo_expire = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Idle-ballot timer: runs only while the FSM stays in ARMED, clears on any exit.
    // ARMED -> OPEN can only be a timeout, so that transition is the pulse source.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == StArmed && state_d == StArmed) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
        tmo_d = (state_q == StArmed) && (state_d == StOpen);
    end

    // Timeout counter and pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign tmo_expire = 1'b0;
    assign timeout    = 1'b0;
`endif

    // Outputs decode from registered state so reset drops them without a clock edge.
    always_comb begin
        vote_grant = (state_q == StGrant) ? grant_q : 4'd0;
        busy       = (state_q == StArmed) || (state_q == StGrant) || (state_q == StLockout);
        disp_en    = (state_q == StFinal);
        state_o    = state_q;
        ballot_cnt = cnt_q;
        err_multi  = err_q;
        disp_sel   = sel_q;
    end

endmodule

// File: tb/tb_ballot_controller.sv
// tb_ballot_controller: directed literal checks plus randomized episodes, all compared
// every cycle against a behavioural poll model kept in this bench.
module tb_ballot_controller;

    localparam int unsigned LOCK = 3;
    localparam int unsigned TMO  = 16;

    localparam int S_CLOSED  = 0;
    localparam int S_OPEN    = 1;
    localparam int S_ARMED   = 2;
    localparam int S_GRANT   = 3;
    localparam int S_LOCKOUT = 4;
    localparam int S_FINAL   = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       open_poll;
    logic       close_poll;
    logic       voter_auth;
    logic [3:0] vote_req;
    logic [3:0] vote_grant;
    logic [9:0] ballot_cnt;
    logic       busy;
    logic       err_multi;
    logic       timeout;
    logic       disp_en;
    logic [1:0] disp_sel;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    ballot_controller #(
        .LOCKOUT_CYCLES(LOCK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .open_poll  (open_poll),
        .close_poll (close_poll),
        .voter_auth (voter_auth),
        .vote_req   (vote_req),
        .vote_grant (vote_grant),
        .ballot_cnt (ballot_cnt),
        .busy       (busy),
        .err_multi  (err_multi),
        .timeout    (timeout),
        .disp_en    (disp_en),
        .disp_sel   (disp_sel),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    int         m_state;
    int         m_cnt;
    bit         m_pend;
    int         m_lock_left;
    int         m_age;
    logic [3:0] m_latched;
    bit         m_err;
    bit         m_tmo;
    int         m_sel;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state     <= S_CLOSED;
            m_cnt       <= 0;
            m_pend      <= 1'b0;
            m_lock_left <= 0;
            m_age       <= 0;
            m_latched   <= 4'd0;
            m_err       <= 1'b0;
            m_tmo       <= 1'b0;
            m_sel       <= 0;
        end else begin
            m_err <= 1'b0;
            m_tmo <= 1'b0;
            case (m_state)
                S_CLOSED: if (open_poll && !close_poll) m_state <= S_OPEN;
                S_OPEN: begin
                    if (close_poll) m_state <= S_FINAL;
                    else if (voter_auth) begin
                        m_state <= S_ARMED;
                        m_age   <= 0;
                    end
                end
                S_ARMED: begin
                    if (close_poll || m_pend) m_state <= S_FINAL;
                    else if ($countones(vote_req) == 1) begin
                        m_latched <= vote_req;
                        m_state   <= S_GRANT;
                    end else begin
                        if ($countones(vote_req) >= 2) m_err <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
                        if (m_age + 1 == TMO) begin
                            m_state <= S_OPEN;
                            m_tmo   <= 1'b1;
                        end else m_age <= m_age + 1;
`endif
                    end
                end
                S_GRANT: begin
                    if (close_poll) m_pend <= 1'b1;
                    m_cnt       <= (m_cnt >= 1023) ? 1023 : m_cnt + 1;
                    m_lock_left <= LOCK;
                    m_state     <= S_LOCKOUT;
                end
                S_LOCKOUT: begin
                    if (close_poll) m_pend <= 1'b1;
                    m_lock_left <= m_lock_left - 1;
                    if (m_lock_left == 1) m_state <= (m_pend || close_poll) ? S_FINAL : S_OPEN;
                end
                S_FINAL: if (vote_req != 4'd0) m_sel <= lowest(vote_req);
                default: m_state <= S_CLOSED;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("state_o", int'(state_o), m_state);
            check("vote_grant", int'(vote_grant),
                  (m_state == S_GRANT) ? int'(m_latched) : 0);
            check("ballot_cnt", int'(ballot_cnt), m_cnt);
            check("busy", int'(busy),
                  (m_state == S_ARMED || m_state == S_GRANT || m_state == S_LOCKOUT) ? 1 : 0);
            check("err_multi", int'(err_multi), int'(m_err));
            check("timeout", int'(timeout), int'(m_tmo));
            check("disp_en", int'(disp_en), (m_state == S_FINAL) ? 1 : 0);
            check("disp_sel", int'(disp_sel), m_sel);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        int n = 0;
        while (int'(state_o) != s && n < limit) begin
            cyc();
            n++;
        end
        check(name, int'(state_o), s);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        open_poll  = 1'b0;
        close_poll = 1'b0;
        voter_auth = 1'b0;
        vote_req   = 4'd0;
        cyc();
        check("rst_state", int'(state_o), 0);
        check("rst_cnt", int'(ballot_cnt), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_grant", int'(vote_grant), 0);
        check("rst_disp_en", int'(disp_en), 0);
        cyc();
        rst = 1'b1;
    endtask

    task automatic do_ballot(input logic [3:0] v);
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        vote_req   = v;
        cyc();
        vote_req   = 4'd0;
        wait_state(S_OPEN, LOCK + 5, "ballot_done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int busy_n;
        int cnt_before;
        int fin;
        int r;

        do_reset();

        // CLOSED holds with both officer inputs high
        open_poll  = 1'b1;
        close_poll = 1'b1;
        cyc();
        check("closed_both_high", int'(state_o), S_CLOSED);
        close_poll = 1'b0;
        cyc();
        check("closed_to_open", int'(state_o), S_OPEN);
        open_poll = 1'b0;

        // vote_req in OPEN is discarded without error
        vote_req = 4'b0011;
        cyc();
        vote_req = 4'd0;
        check("open_discard_err", int'(err_multi), 0);
        check("open_discard_state", int'(state_o), S_OPEN);

        // single grant, lockout length, return to OPEN
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        check("armed", int'(state_o), S_ARMED);
        vote_req = 4'b0100;
        cyc();
        vote_req = 4'd0;
        check("grant_value", int'(vote_grant), 4'b0100);
        check("grant_state", int'(state_o), S_GRANT);
        busy_n = 1;
        cyc();
        check("grant_one_cycle", int'(vote_grant), 0);
        check("cnt_after_first", int'(ballot_cnt), 1);
        while (busy === 1'b1 && busy_n < 50) begin
            busy_n++;
            cyc();
        end
        check("busy_length", busy_n, 1 + LOCK);
        check("lockout_to_open", int'(state_o), S_OPEN);

        // ambiguous ballot then a valid one
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        vote_req = 4'b0011;
        cyc();
        vote_req = 4'd0;
        check("err_pulse", int'(err_multi), 1);
        check("err_stays_armed", int'(state_o), S_ARMED);
        check("err_no_grant", int'(vote_grant), 0);
        cyc();
        check("err_single_cycle", int'(err_multi), 0);
        vote_req = 4'b0001;
        cyc();
        vote_req = 4'd0;
        check("grant_after_err", int'(vote_grant), 4'b0001);
        wait_state(S_OPEN, 20, "second_ballot_open");
        check("cnt_after_second", int'(ballot_cnt), 2);

        // close during lockout defers to FINAL, then display selection
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        vote_req = 4'b0010;
        cyc();
        vote_req = 4'd0;
        cyc();
        close_poll = 1'b1;
        cyc();
        close_poll = 1'b0;
        check("close_deferred", int'(state_o), S_LOCKOUT);
        wait_state(S_FINAL, 20, "lockout_to_final");
        check("final_disp_en", int'(disp_en), 1);
        check("final_cnt", int'(ballot_cnt), 3);
        vote_req = 4'b1000;
        cyc();
        vote_req = 4'd0;
        check("disp_sel_3", int'(disp_sel), 3);
        check("final_no_grant", int'(vote_grant), 0);
        vote_req = 4'b0110;
        cyc();
        vote_req = 4'd0;
        check("disp_sel_lowest", int'(disp_sel), 1);
        voter_auth = 1'b1;
        open_poll  = 1'b1;
        cyc();
        voter_auth = 1'b0;
        open_poll  = 1'b0;
        check("final_terminal", int'(state_o), S_FINAL);

        // reset during GRANT drops outputs without a clock edge
        do_reset();
        open_poll = 1'b1;
        cyc();
        open_poll  = 1'b0;
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        vote_req   = 4'b0100;
        cyc();
        vote_req = 4'd0;
        check("pre_rst_grant", int'(vote_grant), 4'b0100);
        #2 rst = 1'b0;
        #1;
        check("rst_async_grant", int'(vote_grant), 0);
        check("rst_async_state", int'(state_o), 0);
        check("rst_async_busy", int'(busy), 0);
        cyc();
        rst = 1'b1;
        cyc();
        check("rst_cut_cnt", int'(ballot_cnt), 0);

        // armed idle behaviour
        open_poll = 1'b1;
        cyc();
        open_poll  = 1'b0;
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        cnt_before = int'(ballot_cnt);
`ifdef BALLOT_TIMEOUT_EN
        repeat (TMO - 1) cyc();
        check("tmo_not_yet", int'(state_o), S_ARMED);
        cyc();
        check("tmo_pulse", int'(timeout), 1);
        check("tmo_to_open", int'(state_o), S_OPEN);
        check("tmo_cnt_same", int'(ballot_cnt), cnt_before);
        cyc();
        check("tmo_single_cycle", int'(timeout), 0);
`else
        repeat (100) cyc();
        check("armed_waits", int'(state_o), S_ARMED);
        check("no_timeout", int'(timeout), 0);
        check("armed_cnt_same", int'(ballot_cnt), cnt_before);
`endif

        // saturation: 1023 ballots then one more
        do_reset();
        open_poll = 1'b1;
        cyc();
        open_poll = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            do_ballot(4'(1 << (i % 4)));
        end
        check("cnt_1023", int'(ballot_cnt), 1023);
        voter_auth = 1'b1;
        cyc();
        voter_auth = 1'b0;
        vote_req   = 4'b0010;
        cyc();
        vote_req = 4'd0;
        check("sat_grant", int'(vote_grant), 4'b0010);
        cyc();
        check("sat_hold", int'(ballot_cnt), 1023);

        // randomized episodes
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            fin = 0;
            for (int c = 0; c < 400; c++) begin
                open_poll  = ($urandom_range(0, 99) < 20);
                close_poll = ($urandom_range(0, 999) < 5);
                voter_auth = ($urandom_range(0, 99) < 30);
                r = $urandom_range(0, 9);
                if (r < 5) vote_req = 4'd0;
                else if (r < 8) vote_req = 4'(1 << $urandom_range(0, 3));
                else vote_req = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 499) == 0) begin
                    #2 rst = 1'b0;
                    cyc();
                    rst = 1'b1;
                end else begin
                    cyc();
                end
                if (m_state == S_FINAL) fin++;
                if (fin > 15) break;
            end
        end
        open_poll  = 1'b0;
        close_poll = 1'b0;
        voter_auth = 1'b0;
        vote_req   = 4'd0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
